// File: rtl/countdown_timer.sv
// Loadable down-counter with pause/abort control and a one-cycle registered done pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN to restart periodically from the value captured at start.
module countdown_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             zero
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count_nxt;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_nxt;
`endif

    // Decrement that floors at zero so the count can never wrap to all-ones.
    function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
        return (v == '0) ? '0 : v - ONE;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload <= '0;
`endif
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload <= reload_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_nxt = reload;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    count_nxt = load_val;
                    state_nxt = (load_val == '0) ? DONE : RUN;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    reload_nxt = load_val;
`endif
                end
            end
            RUN: begin
                if (abort) begin
                    count_nxt = '0;
                    state_nxt = IDLE;
                end else if (pause) begin
                    state_nxt = PAUSED;
                end else if (count <= ONE) begin
                    count_nxt = '0;
                    state_nxt = DONE;
                end else begin
                    count_nxt = sat_dec(count);
                end
            end
            PAUSED: begin
                // Resuming costs one edge without a decrement, symmetric with entering pause.
                if (abort) begin
                    count_nxt = '0;
                    state_nxt = IDLE;
                end else if (!pause) begin
                    state_nxt = RUN;
                end
            end
            DONE: begin
                count_nxt = '0;
                state_nxt = IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (reload != '0) begin
                    count_nxt = reload;
                    state_nxt = RUN;
                end
`endif
            end
            default: begin
                count_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign zero = (count == '0);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboarded directed bench for countdown_timer; expected outputs are queued per edge
// by the stimulus and consumed by an independent monitor just after each rising edge.
module tb_countdown_timer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] load_val;
    logic       pause;
    logic       abort;
    logic [4:0] count;
    logic       busy;
    logic       done;
    logic       zero;

    typedef struct {
        string      tag;
        logic [4:0] cnt;
        logic       busy;
        logic       done;
        logic       zero;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    countdown_timer #(.WIDTH(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .load_val (load_val),
        .pause    (pause),
        .abort    (abort),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    // Monitor: one queued expectation per rising edge, compared 1 time unit after it.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (count !== e.cnt || busy !== e.busy || done !== e.done || zero !== e.zero) begin
                errors++;
                $display("FAIL %s: got count=%0d busy=%0b done=%0b zero=%0b, expected count=%0d busy=%0b done=%0b zero=%0b",
                         e.tag, count, busy, done, zero, e.cnt, e.busy, e.done, e.zero);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive inputs for one cycle and queue the outputs expected after the next rising edge.
    task automatic step(input string tag, input logic s, input logic [4:0] lv,
                        input logic p, input logic a, input int ec, input logic eb, input logic ed);
        exp_t x;
        @(negedge clk);
        start = s; load_val = lv; pause = p; abort = a;
        x.tag  = tag;
        x.cnt  = ec[4:0];
        x.busy = eb;
        x.done = ed;
        x.zero = (ec == 0);
        exp_q.push_back(x);
        @(posedge clk);
    endtask

    task automatic countdown(input string tag, input int from, input int to);
        for (int c = from; c >= to; c--) step(tag, 1'b0, 5'd0, 1'b0, 1'b0, c, 1'b1, 1'b0);
    endtask

    task automatic direct_check(input string tag, input logic [4:0] ec, input logic eb, input logic ed);
        checks++;
        if (count !== ec || busy !== eb || done !== ed || zero !== (ec == 5'd0)) begin
            errors++;
            $display("FAIL %s: got count=%0d busy=%0b done=%0b zero=%0b, expected count=%0d busy=%0b done=%0b",
                     tag, count, busy, done, zero, ec, eb, ed);
        end
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; load_val = 5'd0; pause = 1'b0; abort = 1'b0;
        #2 rst_n = 1'b0;
        #1 direct_check("reset_async", 5'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step("reset_release", 1'b0, 5'd9, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step("reset_idle",    1'b0, 5'd9, 1'b1, 1'b1, 0, 1'b0, 1'b0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // load 3: period of 4 edges, done on every 0; start during DONE is ignored
        step("ar_start", 1'b1, 5'd3, 1'b0, 1'b0, 3, 1'b1, 1'b0);
        for (int per = 0; per < 3; per++) begin
            countdown("ar_count", 2, 1);
            step("ar_done",   1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
            step("ar_reload", (per == 1), 5'd7, 1'b0, 1'b0, 3, 1'b1, 1'b0);
        end
        countdown("ar_count", 2, 2);
        step("ar_pause",  1'b0, 5'd0, 1'b1, 1'b0, 2, 1'b1, 1'b0);
        step("ar_resume", 1'b0, 5'd0, 1'b0, 1'b0, 2, 1'b1, 1'b0);
        step("ar_abort",  1'b0, 5'd0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        step("ar_idle",   1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        // captured zero behaves as a one-shot
        step("ar_zero_start", 1'b1, 5'd0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        step("ar_zero_idle",  1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step("ar_zero_hold",  1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
`else
        // basic load 5
        step("basic_start", 1'b1, 5'd5, 1'b0, 1'b0, 5, 1'b1, 1'b0);
        countdown("basic_count", 4, 1);
        step("basic_done",  1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        step("basic_idle",  1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step("basic_hold",  1'b0, 5'd17, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // zero load: done on the edge after start
        step("zero_start", 1'b1, 5'd0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        step("zero_idle",  1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // full range 31, no wrap, single done; pause/abort during DONE ignored
        step("full_start", 1'b1, 5'd31, 1'b0, 1'b0, 31, 1'b1, 1'b0);
        countdown("full_count", 30, 1);
        step("full_done",  1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        step("full_idle",  1'b1, 5'd2, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        step("full_hold",  1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // load 10, pause sampled high on 3 edges at count 6, then one resume edge
        step("pause_start", 1'b1, 5'd10, 1'b0, 1'b0, 10, 1'b1, 1'b0);
        countdown("pause_pre", 9, 6);
        for (int i = 0; i < 3; i++) step("pause_hold", 1'b0, 5'd0, 1'b1, 1'b0, 6, 1'b1, 1'b0);
        step("pause_resume", 1'b0, 5'd0, 1'b0, 1'b0, 6, 1'b1, 1'b0);
        countdown("pause_post", 5, 1);
        step("pause_done",  1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        step("pause_idle",  1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // abort at count 4: no done afterwards
        step("abort_start", 1'b1, 5'd6, 1'b0, 1'b0, 6, 1'b1, 1'b0);
        countdown("abort_pre", 5, 4);
        step("abort_hit",   1'b0, 5'd0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        step("abort_nodone", 1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // abort and pause together in RUN: abort wins
        step("ap_start", 1'b1, 5'd7, 1'b0, 1'b0, 7, 1'b1, 1'b0);
        countdown("ap_pre", 6, 6);
        step("ap_both",  1'b0, 5'd0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        step("ap_idle",  1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // abort while paused
        step("pab_start", 1'b1, 5'd5, 1'b0, 1'b0, 5, 1'b1, 1'b0);
        step("pab_pause", 1'b0, 5'd0, 1'b1, 1'b0, 5, 1'b1, 1'b0);
        step("pab_abort", 1'b0, 5'd0, 1'b1, 1'b1, 0, 1'b0, 1'b0);

        // start while busy is ignored
        step("sb_start", 1'b1, 5'd8, 1'b0, 1'b0, 8, 1'b1, 1'b0);
        countdown("sb_pre", 7, 5);
        step("sb_ignored", 1'b1, 5'd3, 1'b0, 1'b0, 4, 1'b1, 1'b0);
        countdown("sb_post", 3, 1);
        step("sb_done",  1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        step("sb_idle",  1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
`endif

        // asynchronous reset in the middle of a count
        step("rst_start", 1'b1, 5'd9, 1'b0, 1'b0, 9, 1'b1, 1'b0);
        countdown("rst_pre", 8, 7);
        #3 rst_n = 1'b0;
        #1 direct_check("rst_midcount", 5'd0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        step("rst_after", 1'b0, 5'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
